// File: rtl/sccb_cfg_engine.sv
// SCCB/I2C sensor configuration engine: walks a register table ROM and drives
// byte-level requests to an i2c_master, with write, readback-verify, delay and retry.
module sccb_cfg_engine #(
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter int         REG_AW     = 16,
    parameter int         REG_DW     = 8,
    parameter int         TBL_DEPTH  = 256,
    parameter int         MAX_RETRY  = 3,
    parameter int         DELAY_UNIT = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [$clog2(TBL_DEPTH)-1:0] tbl_addr,
    input  logic [2+REG_AW+REG_DW-1:0]   tbl_data,
    output logic                         req,
    output logic [3:0]                   cmd,
    output logic [7:0]                   din,
    input  logic [7:0]                   dout,
    input  logic                         done,
    input  logic                         slave_ack,
    output logic                         busy,
    output logic                         cfg_done,
    output logic                         cfg_err,
    output logic [$clog2(TBL_DEPTH)-1:0] err_index
);

    localparam int TAW = $clog2(TBL_DEPTH);
    localparam int EW  = 2 + REG_AW + REG_DW;
    localparam int NAB = REG_AW / 8;
    localparam int NDB = REG_DW / 8;
    localparam int RW  = $clog2(MAX_RETRY + 2);
    localparam int UW  = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;

    localparam logic [2:0] ADDR_LAST = 3'(NAB);
    localparam logic [2:0] W_LAST    = 3'(NAB + NDB);
    localparam logic [2:0] V_RDADDR  = 3'(NAB + 1);
    localparam logic [2:0] V_LAST    = 3'(NAB + NDB + 1);

    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_WRITE = 4'b0010;
    localparam logic [3:0] CMD_READ  = 4'b0100;
    localparam logic [3:0] CMD_STOP  = 4'b1000;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_VERIFY,
        S_DELAY, S_ABORT, S_RETRY, S_ERR, S_DONE
    } state_t;

    state_t              r_state, w_state;
    logic [TAW-1:0]      r_tblAddr, w_tblAddr;
    logic [TAW-1:0]      r_errIndex, w_errIndex;
    logic                r_req, w_req;
    logic [3:0]          r_cmd, w_cmd;
    logic [7:0]          r_din, w_din;
    logic                r_pending, w_pending;
    logic [2:0]          r_step, w_step;
    logic                r_verify, w_verify;
    logic [REG_AW-1:0]   r_regAddr, w_regAddr;
    logic [REG_DW-1:0]   r_regData, w_regData;
    logic [REG_DW-1:0]   r_rdata, w_rdata;
    logic [RW-1:0]       r_retry, w_retry;
    logic [REG_DW-1:0]   r_ticks, w_ticks;
    logic [UW-1:0]       r_unit, w_unit;
    logic                w_advance;

    logic [15:0]         w_addr16, w_data16;
    logic [2:0]          w_addrIdx, w_dataIdx;
    logic [7:0]          w_addrByte, w_dataByte;
    logic [3:0]          w_byteCmd;
    logic [7:0]          w_byteDin;
    logic [REG_DW-1:0]   w_rdataShift;

    assign w_rdataShift = REG_DW'({r_rdata, dout});

    // Byte to send for the current step of a write or verify transaction.
    always_comb begin
        w_addr16   = 16'(r_regAddr);
        w_data16   = 16'(r_regData);
        w_addrIdx  = r_step - 3'd1;
        w_dataIdx  = r_step - 3'(NAB + 1);
        w_addrByte = (NAB == 2 && w_addrIdx == 3'd0) ? w_addr16[15:8] : w_addr16[7:0];
        w_dataByte = (NDB == 2 && w_dataIdx == 3'd0) ? w_data16[15:8] : w_data16[7:0];
        w_byteCmd  = CMD_START | CMD_WRITE;
        w_byteDin  = {DEV_ADDR, 1'b0};
        if (r_step != 3'd0) begin
            if (r_state == S_VERIFY) begin
                if (r_step <= ADDR_LAST) begin
                    w_byteCmd = CMD_WRITE | ((r_step == ADDR_LAST) ? CMD_STOP : 4'b0000);
                    w_byteDin = w_addrByte;
                end else if (r_step == V_RDADDR) begin
                    w_byteDin = {DEV_ADDR, 1'b1};
                end else begin
                    w_byteCmd = CMD_READ | ((r_step == V_LAST) ? CMD_STOP : 4'b0000);
                    w_byteDin = 8'h00;
                end
            end else if (r_step <= ADDR_LAST) begin
                w_byteCmd = CMD_WRITE;
                w_byteDin = w_addrByte;
            end else begin
                w_byteCmd = CMD_WRITE | ((r_step == W_LAST) ? CMD_STOP : 4'b0000);
                w_byteDin = w_dataByte;
            end
        end
    end

    always_comb begin
        w_state    = r_state;
        w_tblAddr  = r_tblAddr;
        w_errIndex = r_errIndex;
        w_req      = 1'b0;
        w_cmd      = r_cmd;
        w_din      = r_din;
        w_pending  = r_pending;
        w_step     = r_step;
        w_verify   = r_verify;
        w_regAddr  = r_regAddr;
        w_regData  = r_regData;
        w_rdata    = r_rdata;
        w_retry    = r_retry;
        w_ticks    = r_ticks;
        w_unit     = r_unit;
        w_advance  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state    = S_FETCH;
                    w_tblAddr  = '0;
                    w_retry    = '0;
                    w_errIndex = '0;
                end
            end
            S_FETCH: w_state = S_DECODE;
            S_DECODE: begin
                w_regAddr = tbl_data[REG_AW+REG_DW-1:REG_DW];
                w_regData = tbl_data[REG_DW-1:0];
                w_step    = 3'd0;
                w_pending = 1'b0;
                w_rdata   = '0;
                case (tbl_data[EW-1:EW-2])
                    2'b00: begin w_verify = 1'b0; w_state = S_WRITE; end
                    2'b01: begin w_verify = 1'b1; w_state = S_WRITE; end
                    2'b10: begin
                        w_ticks = tbl_data[REG_DW-1:0];
                        w_unit  = '0;
                        if (tbl_data[REG_DW-1:0] == '0) w_advance = 1'b1;
                        else                            w_state   = S_DELAY;
                    end
                    default: w_state = S_DONE;
                endcase
            end
            S_WRITE, S_VERIFY: begin
                if (!r_pending) begin
                    w_req     = 1'b1;
                    w_cmd     = w_byteCmd;
                    w_din     = w_byteDin;
                    w_pending = 1'b1;
                end else if (done) begin
                    w_pending = 1'b0;
                    // A NACK on any byte carrying WRITE aborts the whole entry.
                    if (r_cmd[1] && slave_ack) begin
                        w_state = S_ABORT;
                    end else begin
                        if (r_cmd[2]) w_rdata = w_rdataShift;
                        if (r_state == S_WRITE && r_step == W_LAST) begin
                            w_step = 3'd0;
                            if (r_verify) w_state   = S_VERIFY;
                            else          w_advance = 1'b1;
                        end else if (r_state == S_VERIFY && r_step == V_LAST) begin
                            if (w_rdataShift == r_regData) w_advance = 1'b1;
                            else                           w_state   = S_RETRY;
                        end else begin
                            w_step = r_step + 3'd1;
                        end
                    end
                end
            end
            S_DELAY: begin
                if (r_ticks == '0) begin
                    w_advance = 1'b1;
                end else if (r_unit == UW'(DELAY_UNIT - 1)) begin
                    w_unit  = '0;
                    w_ticks = r_ticks - 1'b1;
                end else begin
                    w_unit = r_unit + 1'b1;
                end
            end
            S_ABORT: begin
                if (!r_pending) begin
                    w_req     = 1'b1;
                    w_cmd     = CMD_STOP;
                    w_din     = 8'h00;
                    w_pending = 1'b1;
                end else if (done) begin
                    w_pending = 1'b0;
                    w_state   = S_RETRY;
                end
            end
            S_RETRY: begin
                w_retry = r_retry + 1'b1;
                if (r_retry < RW'(MAX_RETRY)) begin
                    w_state = S_FETCH;
                end else begin
                    w_state    = S_ERR;
                    w_errIndex = r_tblAddr;
                end
            end
            default: w_state = S_IDLE;
        endcase
        // The last table slot ends configuration instead of wrapping to 0.
        if (w_advance) begin
            w_retry = '0;
            if (r_tblAddr == TAW'(TBL_DEPTH - 1)) begin
                w_state = S_DONE;
            end else begin
                w_tblAddr = r_tblAddr + 1'b1;
                w_state   = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tblAddr  <= '0;
            r_errIndex <= '0;
            r_req      <= 1'b0;
            r_cmd      <= 4'b0000;
            r_din      <= 8'h00;
            r_pending  <= 1'b0;
            r_step     <= 3'd0;
            r_verify   <= 1'b0;
            r_regAddr  <= '0;
            r_regData  <= '0;
            r_rdata    <= '0;
            r_retry    <= '0;
            r_ticks    <= '0;
            r_unit     <= '0;
        end else begin
            r_tblAddr  <= w_tblAddr;
            r_errIndex <= w_errIndex;
            r_req      <= w_req;
            r_cmd      <= w_cmd;
            r_din      <= w_din;
            r_pending  <= w_pending;
            r_step     <= w_step;
            r_verify   <= w_verify;
            r_regAddr  <= w_regAddr;
            r_regData  <= w_regData;
            r_rdata    <= w_rdata;
            r_retry    <= w_retry;
            r_ticks    <= w_ticks;
            r_unit     <= w_unit;
        end
    end

    assign tbl_addr  = r_tblAddr;
    assign err_index = r_errIndex;
    assign req       = r_req;
    assign cmd       = r_cmd;
    assign din       = r_din;
    assign busy      = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign cfg_done  = (r_state == S_DONE);
    assign cfg_err   = (r_state == S_ERR);

endmodule

// File: tb/tb_sccb_cfg_engine.sv
// Directed bench for sccb_cfg_engine: two instances (16/8 and 8/16 address/data)
// driven by small table ROMs and an i2c_master stand-in that logs every request.
`timescale 1ns/1ps
module tb_sccb_cfg_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 16-bit register address, 8-bit data
    logic        startA = 1'b0, reqA, busyA, cfgDoneA, cfgErrA;
    logic        doneRspA = 1'b0, strayDoneA = 1'b0, doneA, ackA = 1'b0;
    logic [2:0]  tblAddrA, errIndexA;
    logic [25:0] tblDataA;
    logic [3:0]  cmdA, lastCmdA;
    logic [7:0]  dinA, lastDinA, doutA = 8'h00;
    logic [25:0] romA [0:7];
    logic [3:0]  logCmdA [0:63];
    logic [7:0]  logDinA [0:63];
    int          logTimeA [0:63];
    int          nA = 0, waitA = 0, nacksGivenA = 0, nackLimitA = 0, tStartA = 0;

    assign doneA = doneRspA | strayDoneA;

    sccb_cfg_engine #(.DEV_ADDR(7'h3C), .REG_AW(16), .REG_DW(8), .TBL_DEPTH(8),
                      .MAX_RETRY(3), .DELAY_UNIT(10)) dutA (
        .clk(clk), .rst(rst), .start(startA), .tbl_addr(tblAddrA), .tbl_data(tblDataA),
        .req(reqA), .cmd(cmdA), .din(dinA), .dout(doutA), .done(doneA), .slave_ack(ackA),
        .busy(busyA), .cfg_done(cfgDoneA), .cfg_err(cfgErrA), .err_index(errIndexA)
    );

    always_ff @(posedge clk) tblDataA <= romA[tblAddrA];

    // Master stand-in A: answers each request two cycles later; can NACK address byte 0x30.
    always @(posedge clk) begin
        doneRspA <= 1'b0;
        if (startA) tStartA <= cyc;
        if (rst) begin
            waitA       <= 0;
            nacksGivenA <= 0;
        end else if (reqA) begin
            if (nA < 64) begin
                logCmdA[nA]  <= cmdA;
                logDinA[nA]  <= dinA;
                logTimeA[nA] <= cyc;
            end
            nA       <= nA + 1;
            lastCmdA <= cmdA;
            lastDinA <= dinA;
            waitA    <= 2;
        end else if (waitA != 0) begin
            waitA <= waitA - 1;
            if (waitA == 1) begin
                doneRspA <= 1'b1;
                doutA    <= 8'h00;
                if (lastCmdA == 4'b0010 && lastDinA == 8'h30 && nacksGivenA < nackLimitA) begin
                    ackA        <= 1'b1;
                    nacksGivenA <= nacksGivenA + 1;
                end else begin
                    ackA <= 1'b0;
                end
            end
        end
    end

    // Instance B: 8-bit register address, 16-bit data
    logic        startB = 1'b0, reqB, busyB, cfgDoneB, cfgErrB;
    logic        doneB = 1'b0, ackB = 1'b0;
    logic [1:0]  tblAddrB, errIndexB;
    logic [25:0] tblDataB;
    logic [3:0]  cmdB, lastCmdB;
    logic [7:0]  dinB, doutB = 8'h00;
    logic [15:0] rdWordB = 16'h0000;
    logic [25:0] romB [0:3];
    logic [3:0]  logCmdB [0:63];
    logic [7:0]  logDinB [0:63];
    int          nB = 0, waitB = 0, readIdxB = 0;

    sccb_cfg_engine #(.DEV_ADDR(7'h3C), .REG_AW(8), .REG_DW(16), .TBL_DEPTH(4),
                      .MAX_RETRY(3), .DELAY_UNIT(10)) dutB (
        .clk(clk), .rst(rst), .start(startB), .tbl_addr(tblAddrB), .tbl_data(tblDataB),
        .req(reqB), .cmd(cmdB), .din(dinB), .dout(doutB), .done(doneB), .slave_ack(ackB),
        .busy(busyB), .cfg_done(cfgDoneB), .cfg_err(cfgErrB), .err_index(errIndexB)
    );

    always_ff @(posedge clk) tblDataB <= romB[tblAddrB];

    // Master stand-in B: always ACKs; READ bytes return rdWordB high byte first.
    always @(posedge clk) begin
        doneB <= 1'b0;
        if (rst) begin
            waitB <= 0;
        end else if (reqB) begin
            if (nB < 64) begin
                logCmdB[nB] <= cmdB;
                logDinB[nB] <= dinB;
            end
            nB       <= nB + 1;
            lastCmdB <= cmdB;
            if (cmdB[0]) readIdxB <= 0;
            waitB    <= 2;
        end else if (waitB != 0) begin
            waitB <= waitB - 1;
            if (waitB == 1) begin
                doneB <= 1'b1;
                ackB  <= 1'b0;
                if (lastCmdB[2]) begin
                    doutB    <= (readIdxB == 0) ? rdWordB[15:8] : rdWordB[7:0];
                    readIdxB <= readIdxB + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse start on one instance and wait (bounded) for busy to drop; optionally
    // re-pulse start partway through to show it is ignored while busy.
    task automatic applyStimulus(input bit selB, input int budget, input int restrikeAt);
        @(negedge clk);
        if (selB) startB = 1'b1; else startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (i == restrikeAt) begin
                if (selB) startB = 1'b1; else startA = 1'b1;
            end else begin
                startA = 1'b0;
                startB = 1'b0;
            end
            @(negedge clk);
            if (!(selB ? busyB : busyA)) break;
        end
        startA = 1'b0;
        startB = 1'b0;
        checkOutput(selB ? "B_finished" : "A_finished", selB ? busyB : busyA, 0);
    endtask

    int base;

    initial begin
        for (int i = 0; i < 8; i++) romA[i] = 26'h0;
        for (int i = 0; i < 4; i++) romB[i] = 26'h0;
        doReset();

        checkOutput("rst_req",      reqA, 0);
        checkOutput("rst_busy",     busyA, 0);
        checkOutput("rst_cfg_done", cfgDoneA, 0);
        checkOutput("rst_cfg_err",  cfgErrA, 0);
        checkOutput("rst_tbl_addr", tblAddrA, 0);
        checkOutput("rst_err_idx",  errIndexA, 0);

        // Single write, start re-pulsed mid-run, stray done while idle
        romA[0] = {2'b00, 16'h3008, 8'h82};
        romA[1] = {2'b11, 24'h0};
        @(negedge clk); strayDoneA = 1'b1;
        @(negedge clk); strayDoneA = 1'b0;
        base = nA;
        applyStimulus(0, 300, 6);
        checkOutput("wr_req_count", nA - base, 4);
        checkOutput("wr_b0_cmd", logCmdA[base],   4'h3); checkOutput("wr_b0_din", logDinA[base],   8'h78);
        checkOutput("wr_b1_cmd", logCmdA[base+1], 4'h2); checkOutput("wr_b1_din", logDinA[base+1], 8'h30);
        checkOutput("wr_b2_cmd", logCmdA[base+2], 4'h2); checkOutput("wr_b2_din", logDinA[base+2], 8'h08);
        checkOutput("wr_b3_cmd", logCmdA[base+3], 4'hA); checkOutput("wr_b3_din", logDinA[base+3], 8'h82);
        checkOutput("wr_cfg_done", cfgDoneA, 1);
        checkOutput("wr_cfg_err",  cfgErrA, 0);
        checkOutput("wr_tbl_addr", tblAddrA, 1);

        // Two NACKs on the first address byte, then success
        nackLimitA = 2;
        doReset();
        base = nA;
        applyStimulus(0, 500, -1);
        checkOutput("nack_req_count", nA - base, 10);
        checkOutput("nack_stop1_cmd", logCmdA[base+2], 4'h8);
        checkOutput("nack_stop2_cmd", logCmdA[base+5], 4'h8);
        checkOutput("nack_retry_hdr", logDinA[base+6], 8'h78);
        checkOutput("nack_last_cmd",  logCmdA[base+9], 4'hA);
        checkOutput("nack_last_din",  logDinA[base+9], 8'h82);
        checkOutput("nack_cfg_done",  cfgDoneA, 1);
        nackLimitA = 0;

        // Delay of 5 ticks x 10 cycles before a write
        romA[0] = {2'b10, 16'h0000, 8'd5};
        romA[1] = {2'b00, 16'h3008, 8'h82};
        romA[2] = {2'b11, 24'h0};
        doReset();
        base = nA;
        applyStimulus(0, 500, -1);
        checkOutput("dly5_req_count", nA - base, 4);
        checkOutput("dly5_min_wait", (logTimeA[base] - tStartA) >= 52, 1);
        checkOutput("dly5_cfg_done", cfgDoneA, 1);
        checkOutput("dly5_tbl_addr", tblAddrA, 2);

        // Zero-length delay must not stall
        romA[0] = {2'b10, 16'h0000, 8'd0};
        doReset();
        base = nA;
        applyStimulus(0, 500, -1);
        checkOutput("dly0_no_stall", (logTimeA[base] - tStartA) <= 8, 1);
        checkOutput("dly0_cfg_done", cfgDoneA, 1);

        // Full table with no end marker stops at the last index
        for (int i = 0; i < 8; i++) romA[i] = {2'b10, 16'h0000, 8'd0};
        doReset();
        base = nA;
        applyStimulus(0, 500, -1);
        checkOutput("full_tbl_addr", tblAddrA, 7);
        checkOutput("full_cfg_done", cfgDoneA, 1);
        checkOutput("full_req_count", nA - base, 0);

        // Reset during the data byte
        romA[0] = {2'b00, 16'h3008, 8'h82};
        romA[1] = {2'b11, 24'h0};
        doReset();
        base = nA;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        for (int i = 0; i < 200 && (nA - base) < 4; i++) @(negedge clk);
        checkOutput("midrst_reached", nA - base, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_req",      reqA, 0);
        checkOutput("midrst_cmd",      cmdA, 0);
        checkOutput("midrst_din",      dinA, 0);
        checkOutput("midrst_tbl_addr", tblAddrA, 0);
        checkOutput("midrst_busy",     busyA, 0);
        checkOutput("midrst_cfg_done", cfgDoneA, 0);
        checkOutput("midrst_cfg_err",  cfgErrA, 0);
        checkOutput("midrst_err_idx",  errIndexA, 0);
        repeat (30) @(negedge clk);
        checkOutput("midrst_no_stop",   nA - base, 4);
        checkOutput("midrst_no_autost", busyA, 0);

        // Readback verify, matching data
        romB[0] = {2'b01, 8'h12, 16'hA55A};
        romB[1] = {2'b11, 24'h0};
        rdWordB = 16'hA55A;
        doReset();
        base = nB;
        applyStimulus(1, 500, -1);
        checkOutput("vfy_req_count", nB - base, 9);
        checkOutput("vfy_wdata_lo",  logDinB[base+3], 8'h5A);
        checkOutput("vfy_wdata_cmd", logCmdB[base+3], 4'hA);
        checkOutput("vfy_addr_cmd",  logCmdB[base+5], 4'hA);
        checkOutput("vfy_rd_hdr",    logDinB[base+6], 8'h79);
        checkOutput("vfy_rd_last",   logCmdB[base+8], 4'hC);
        checkOutput("vfy_cfg_done",  cfgDoneB, 1);
        checkOutput("vfy_cfg_err",   cfgErrB, 0);

        // Readback verify, mismatching data -> retries exhausted
        rdWordB = 16'hA500;
        doReset();
        base = nB;
        applyStimulus(1, 2000, -1);
        checkOutput("vbad_req_count", nB - base, 36);
        checkOutput("vbad_cfg_err",   cfgErrB, 1);
        checkOutput("vbad_cfg_done",  cfgDoneB, 0);
        checkOutput("vbad_err_idx",   errIndexB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
